// File: rtl/serial_transmitter.sv
// Serial frame transmitter: start bit, DATA_WIDTH data bits LSB first, optional even parity,
// stop bit, each held for CLKS_PER_BIT clocks. All outputs are registered.
module serial_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  tx_out,
  output logic                  ready,
  output logic                  done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state_q;
  logic [CntW-1:0]       sample_cnt_q;
  logic [IdxW-1:0]       bit_idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  parity_q;
  logic                  bit_end;

  assign shift_next = shift_q >> 1;
  assign bit_end    = (sample_cnt_q == CntLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      sample_cnt_q <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tx_out       <= 1'b1;
      ready        <= 1'b1;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q != StIdle) begin
        sample_cnt_q <= bit_end ? '0 : sample_cnt_q + 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (load) begin
            shift_q      <= data_in;
            parity_q     <= ^data_in;
            sample_cnt_q <= '0;
            bit_idx_q    <= '0;
            tx_out       <= 1'b0;
            ready        <= 1'b0;
            state_q      <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            tx_out  <= shift_q[0];
            state_q <= StData;
          end
        end
        StData: begin
          if (bit_end) begin
            shift_q   <= shift_next;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == IdxLast) begin
              if (PARITY_EN != 0) begin
                tx_out  <= parity_q;
                state_q <= StParity;
              end else begin
                tx_out  <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              // Register the next bit now so the line changes exactly on the boundary edge
              tx_out <= shift_next[0];
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            tx_out  <= 1'b1;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (bit_end) begin
            ready   <= 1'b1;
            done    <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          tx_out  <= 1'b1;
          ready   <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter: one instance without parity, one with even parity.
module tb_serial_transmitter;

  logic       clk;
  logic       reset;
  logic       load0, load1;
  logic [7:0] data0, data1;
  logic       tx0, ready0, done0;
  logic       tx1, ready1, done1;
  int         sel;
  logic       tx_s, ready_s, done_s;
  int         checks;
  int         errors;

  serial_transmitter #(.CLKS_PER_BIT(16), .DATA_WIDTH(8), .PARITY_EN(0)) dut0 (
    .clk     (clk),
    .reset   (reset),
    .load    (load0),
    .data_in (data0),
    .tx_out  (tx0),
    .ready   (ready0),
    .done    (done0)
  );

  serial_transmitter #(.CLKS_PER_BIT(16), .DATA_WIDTH(8), .PARITY_EN(1)) dut1 (
    .clk     (clk),
    .reset   (reset),
    .load    (load1),
    .data_in (data1),
    .tx_out  (tx1),
    .ready   (ready1),
    .done    (done1)
  );

  assign tx_s    = (sel == 1) ? tx1 : tx0;
  assign ready_s = (sel == 1) ? ready1 : ready0;
  assign done_s  = (sel == 1) ? done1 : done0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      edge1();
      check({tag, "_tx"}, 32'(tx_s), 32'd1);
      check({tag, "_ready"}, 32'(ready_s), 32'd1);
      check({tag, "_done"}, 32'(done_s), 32'd0);
    end
  endtask

  // Presents d for one edge; with hold set, load stays high afterwards.
  task automatic start_frame(input int s, input logic [7:0] d, input bit hold);
    if (s == 1) begin
      load1 = 1'b1;
      data1 = d;
    end else begin
      load0 = 1'b1;
      data0 = d;
    end
    edge1();
    if (s == 1) begin
      load1 = 1'b0;
      data1 = ~d;
    end else begin
      if (!hold) load0 = 1'b0;
      data0 = ~d;
    end
  endtask

  // Called just after the accepting edge; returns just after the completion edge.
  // exp bit k is the value expected on the line during frame bit k.
  task automatic check_frame(input string tag, input logic [10:0] exp, input int nbits,
                             input int busy_at);
    int total;
    total = 16 * nbits;
    for (int t = 0; t <= total; t++) begin
      if (t > 0) edge1();
      if (busy_at > 0 && t == busy_at - 1) begin
        load0 = 1'b1;
        data0 = 8'hFF;
      end
      if (busy_at > 0 && t == busy_at) load0 = 1'b0;
      if (t == 0) check({tag, "_start_edge"}, 32'(tx_s), 32'd0);
      if (t < total) begin
        check({tag, "_ready_busy"}, 32'(ready_s), 32'd0);
        check({tag, "_done_busy"}, 32'(done_s), 32'd0);
        if (t % 16 == 8) check({tag, "_bit"}, 32'(tx_s), 32'(exp[t/16]));
      end else begin
        check({tag, "_ready_end"}, 32'(ready_s), 32'd1);
        check({tag, "_done_end"}, 32'(done_s), 32'd1);
        check({tag, "_tx_end"}, 32'(tx_s), 32'd1);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sel    = 0;
    reset  = 1'b1;
    load0  = 1'b0;
    load1  = 1'b0;
    data0  = 8'h00;
    data1  = 8'h00;

    // Reset values
    #1;
    check("rst_async_tx", 32'(tx0), 32'd1);
    check("rst_async_ready", 32'(ready0), 32'd1);
    for (int i = 0; i < 3; i++) begin
      edge1();
      check("rst_tx", 32'(tx0), 32'd1);
      check("rst_ready", 32'(ready0), 32'd1);
      check("rst_done", 32'(done0), 32'd0);
    end
    reset = 1'b0;
    idle_check("idle0", 10);
    sel = 1;
    idle_check("idle1", 2);

    // Single frame 0xA5, no parity
    sel = 0;
    start_frame(0, 8'hA5, 1'b0);
    check_frame("a5", 11'b0_1_1010_0101_0, 10, 0);
    idle_check("a5_after", 3);

    // Parity frames
    sel = 1;
    start_frame(1, 8'h07, 1'b0);
    check_frame("p07", 11'b1_1_0000_0111_0, 11, 0);
    idle_check("p07_after", 2);
    start_frame(1, 8'h03, 1'b0);
    check_frame("p03", 11'b1_0_0000_0011_0, 11, 0);
    idle_check("p03_after", 2);

    // Load while busy is ignored
    sel = 0;
    start_frame(0, 8'h3C, 1'b0);
    check_frame("busy3c", 11'b0_1_0011_1100_0, 10, 50);
    idle_check("busy_after", 40);

    // Back-to-back with load held high
    start_frame(0, 8'h55, 1'b1);
    check_frame("b2b55", 11'b0_1_0101_0101_0, 10, 0);
    data0 = 8'hAA;
    edge1();
    load0 = 1'b0;
    data0 = 8'h00;
    check_frame("b2baa", 11'b0_1_1010_1010_0, 10, 0);
    idle_check("b2b_after", 3);

    // Reset mid-frame, asynchronous
    start_frame(0, 8'hA5, 1'b0);
    repeat (69) edge1();
    check("mid_pre_ready", 32'(ready0), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_tx", 32'(tx0), 32'd1);
    check("mid_rst_ready", 32'(ready0), 32'd1);
    check("mid_rst_done", 32'(done0), 32'd0);
    for (int i = 0; i < 2; i++) begin
      edge1();
      check("mid_hold_done", 32'(done0), 32'd0);
      check("mid_hold_tx", 32'(tx0), 32'd1);
    end
    @(negedge clk);
    reset = 1'b0;
    idle_check("mid_idle", 3);
    start_frame(0, 8'h81, 1'b0);
    check_frame("post81", 11'b0_1_1000_0001_0, 10, 0);
    idle_check("post81_after", 2);

    // Reset and load together: reset wins
    reset = 1'b1;
    load0 = 1'b1;
    data0 = 8'h00;
    edge1();
    load0 = 1'b0;
    reset = 1'b0;
    idle_check("rst_load", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_transmitter.md
# serial_transmitter

Transmit end of the Lab 4 serial link. It accepts a parallel byte and shifts it out as an asynchronous frame: a start bit, data bits LSB first, an optional even-parity bit, and a stop bit. Each bit is held for `CLKS_PER_BIT` system clocks, which matches the 16x oversampling rate the receiver's bit sampling counter (BSC) assumes. It sits between the parallel data source and the serial line that feeds the receiver (BSC/BIC/shift-register path).

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: system clocks per serial bit; must be ≥ 2.
- `DATA_WIDTH`, default 8: data bits per frame.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit after the data bits.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `load`  input  1  frame request; sampled on the rising edge of `clk`.
- `data_in`  input  DATA_WIDTH  byte to send; captured when `load` is accepted.
- `tx_out`  output  1  serial line; idles high.
- `ready`  output  1  high when idle and able to accept `load`.
- `done`  output  1  one-cycle pulse when the stop bit has completed.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset (asynchronous, immediate, including mid-frame) forces:
  - state IDLE, `tx_out`=1, `ready`=1, `done`=0;
  - bit counter, sample counter and shift register to 0.
- IDLE:
  - `tx_out`=1, `ready`=1.
  - `load`=1 at an edge captures `data_in` into the shift register, clears both counters, computes parity as XOR of `data_in`, and enters START.
- START: `tx_out`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - `tx_out` = shift register bit 0.
  - Every CLKS_PER_BIT cycles: shift right by one, increment the bit index.
  - After DATA_WIDTH bits, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: `tx_out` = captured parity bit for CLKS_PER_BIT cycles, then STOP.
- STOP: `tx_out`=1 for CLKS_PER_BIT cycles, then IDLE with `done`=1 for exactly one cycle.
- Sample counter:
  - width $clog2(CLKS_PER_BIT);
  - counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
- Bit index: width $clog2(DATA_WIDTH)+1, so DATA_WIDTH itself is representable without overflow.
- `load` while `ready`=0 is ignored: no capture, no effect on the frame in progress.
- `data_in` changes after capture have no effect on the frame.
- `tx_out`, `ready` and `done` are registered outputs: no combinational path from any input.

## Timing
- Edge numbering: let E0 be the edge that accepts `load`; En is n clocks later.
- Start bit: `tx_out`=0 from E0 until E16 (for CLKS_PER_BIT=16). `ready` falls at E0.
- Data bit i: driven from E(16·(i+1)) to E(16·(i+2)).
- Stop bit:
  - PARITY_EN=0: E144–E160.
  - PARITY_EN=1: parity bit E144–E160, stop bit E160–E176.
- Completion, at E160 (E176 with parity):
  - state IDLE, `ready`=1, `done`=1;
  - `done` clears at the next edge.
- Total frame: (2 + DATA_WIDTH + PARITY_EN) · CLKS_PER_BIT cycles.
- Back-to-back frames:
  - `load` held high at the completion edge is not accepted there, because `ready` is still 0 before that edge;
  - it is accepted at the following edge, the cycle in which `done`=1;
  - so at least one idle-high cycle separates consecutive frames.
- Simultaneous `reset` and `load`: reset wins; nothing is captured.

## Test plan
- **Reset values:** assert `reset` for 3 cycles, idle 10 cycles -> `tx_out`=1, `ready`=1, `done`=0 throughout; `load` held 0.
- **Single frame, 0xA5, PARITY_EN=0:**
  - Stimulus: `load`=1 for one cycle at E0.
  - Required: sampling `tx_out` at E8+16k gives 0,1,0,1,0,0,1,0,1,1.
  - Required: `ready`=0 over E0–E159, `done` high only in cycle E160.
- **Parity, 0x07, PARITY_EN=1:**
  - Required: bit sequence 0,1,1,1,0,0,0,0,0,1,1, where the parity bit is 1.
  - Required: `done` at E176.
  - Also check 0x03: the parity bit is 0.
- **Load while busy:**
  - Stimulus: send 0x3C, then pulse `load` with `data_in`=0xFF at E50.
  - Required: the line still carries 0x3C; no second frame starts.
- **Back-to-back:**
  - Stimulus: hold `load`=1 with 0x55, then 0xAA.
  - Required: the second start bit begins at E161 (the edge while `done`=1); both bytes appear in order.
- **Reset mid-frame:**
  - Stimulus: assert `reset` at E70 between edges.
  - Required: `tx_out`=1 and `ready`=1 immediately, without waiting for a clock edge; `done` never pulses.
  - Required: a subsequent `load` of 0x81 yields a clean, correct frame.
